chunked_adder: RTL

//   Parametrised multi-cycle add/subtract unit for the MIPS datapath; successor to the 1-bit full adder.

---
 rtl/chunked_adder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock with the inter-chunk carry held in a
// register, then publishes sum and flags together with a one-cycle Done pulse.
module chunked_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
  logic              chunk_cout, msb_cin;
  logic [WIDTH-1:0]  acc_next;

  // Operands shift right one chunk per cycle so the low chunk is always the one being added;
  // results enter the accumulator from the top and reach their final position after NCHUNK cycles.
  always_comb begin
    a_chunk = a_q[CHUNK-1:0];
    b_chunk = b_q[CHUNK-1:0];
    {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the MSB sum bit.
    msb_cin  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    acc_next = (acc_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          a_d     = A;
          b_d     = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : CarryIn;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == CntW'(NCHUNK - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_next;
          cout_d  = chunk_cout;
          ovf_d   = msb_cin ^ chunk_cout;
          zero_d  = (acc_next == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Sum      = sum_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule
